// File: rtl/core101_pkg.sv
// Shared types and constants for the core sequencer slice:
// FSM states, ALU operation codes and RISC-V major opcodes.
package core101_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } seq_state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] alu_from_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [3:0] r;
        r = ALU_ADD;
        case (f3)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/core_seq_decoder.sv
// Combinational instruction decoder for the core sequencer.
// Conditional branches are decoded only when CORE_SEQ_BRANCH_EN is defined.
module core_seq_decoder
    import core101_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_opcode,
    output logic       alu_sel_imm,
    output logic       wb_en,
    output logic       is_branch,
    output logic       illegal
);

    logic is_op;
    logic is_imm;
    logic is_br;
    logic f7_base;
    logic f7_alt;

    assign is_op   = (opcode == OPC_OP);
    assign is_imm  = (opcode == OPC_OP_IMM);
    assign is_br   = (opcode == OPC_BRANCH);
    assign f7_base = (funct7 == F7_BASE);
    assign f7_alt  = (funct7 == F7_ALT);

    always_comb begin
        alu_opcode  = ALU_ADD;
        alu_sel_imm = 1'b0;
        wb_en       = 1'b0;
        is_branch   = 1'b0;
        illegal     = 1'b0;
        unique case (1'b1)
            is_op: begin
                wb_en      = 1'b1;
                alu_opcode = alu_from_f3(funct3, funct7[5]);
                illegal    = !(f7_base ||
                               (f7_alt && (funct3 == 3'b000 ||
                                           funct3 == 3'b101)));
            end
            is_imm: begin
                alu_sel_imm = 1'b1;
                wb_en       = 1'b1;
                // only SRAI looks at funct7; other immediates own those bits
                alu_opcode  = alu_from_f3(funct3,
                                          funct3 == 3'b101 && funct7[5]);
                illegal     = (funct3 == 3'b001 && !f7_base) ||
                              (funct3 == 3'b101 && !f7_base && !f7_alt);
            end
            is_br: begin
`ifdef CORE_SEQ_BRANCH_EN
                is_branch = 1'b1;
                case (funct3)
                    3'b000, 3'b001: alu_opcode = ALU_SUB;
                    3'b100, 3'b101: alu_opcode = ALU_SLT;
                    3'b110, 3'b111: alu_opcode = ALU_SLTU;
                    default:        illegal    = 1'b1;
                endcase
`else
                illegal = 1'b1;
`endif
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with sticky halt.
// Define CORE_SEQ_BRANCH_EN to enable conditional branch handling.
module core_sequencer
    import core101_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [31:0] ins_mem_ins,
    input  logic        ins_mem_valid,
    output logic        ins_mem_req,
    output logic [31:0] ins_mem_addr,
    input  logic        stall_in,
    input  logic [31:0] alu_output,
    output logic [3:0]  alu_opcode,
    output logic        alu_sel_imm,
    output logic [31:0] imm_gen_input,
    output logic [4:0]  rf_rs1_addr,
    output logic [4:0]  rf_rs2_addr,
    output logic [4:0]  rf_rd_addr,
    output logic        rf_we,
    output logic        halt
);

    seq_state_t  state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        wb_en_q;
    logic        br_q;

    logic [3:0]  dec_alu_opcode;
    logic        dec_sel_imm;
    logic        dec_wb_en;
    logic        dec_branch;
    logic        dec_illegal;

    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc_next;

    core_seq_decoder u_decoder (
        .opcode      (ir[6:0]),
        .funct3      (ir[14:12]),
        .funct7      (ir[31:25]),
        .alu_opcode  (dec_alu_opcode),
        .alu_sel_imm (dec_sel_imm),
        .wb_en       (dec_wb_en),
        .is_branch   (dec_branch),
        .illegal     (dec_illegal)
    );

    // condition evaluated on the ALU result of the held compare op
    always_comb begin
        br_taken = 1'b0;
        case (ir[14:12])
            3'b000:         br_taken = (alu_output == 32'd0);
            3'b001:         br_taken = (alu_output != 32'd0);
            3'b100, 3'b110: br_taken = alu_output[0];
            3'b101, 3'b111: br_taken = !alu_output[0];
            default:        br_taken = 1'b0;
        endcase
    end

    assign br_target = pc + b_imm(ir);
    assign pc_next   = (br_q && br_taken) ? br_target : pc + 32'd4;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            ir          <= 32'd0;
            ins_mem_req <= 1'b0;
            alu_opcode  <= ALU_ADD;
            alu_sel_imm <= 1'b0;
            wb_en_q     <= 1'b0;
            br_q        <= 1'b0;
            halt        <= 1'b0;
        end else if (!stall_in) begin
            unique case (state)
                ST_IDLE: begin
                    state       <= ST_FETCH;
                    ins_mem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (ins_mem_valid) begin
                        ir          <= ins_mem_ins;
                        state       <= ST_DECODE;
                        ins_mem_req <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        state <= ST_HALT;
                        halt  <= 1'b1;
                    end else begin
                        alu_opcode  <= dec_alu_opcode;
                        alu_sel_imm <= dec_sel_imm;
                        wb_en_q     <= dec_wb_en;
                        br_q        <= dec_branch;
                        state       <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    state <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    if (br_q && br_taken && (br_target[1:0] != 2'b00)) begin
                        state <= ST_HALT;
                        halt  <= 1'b1;
                    end else begin
                        pc          <= pc_next;
                        state       <= ST_FETCH;
                        ins_mem_req <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state       <= ST_HALT;
                    ins_mem_req <= 1'b0;
                    halt        <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    ins_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign rf_we = (state == ST_WRITEBACK) && wb_en_q && !stall_in && !RESET;

    assign ins_mem_addr  = pc;
    assign imm_gen_input = ir;
    assign rf_rs1_addr   = ir[19:15];
    assign rf_rs2_addr   = ir[24:20];
    assign rf_rd_addr    = ir[11:7];

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed instructions, monitor
// compares fetch, writeback and halt events against a queue of expectations.
module tb_core_sequencer;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_WB    = 2'd1;
    localparam logic [1:0] K_HALT  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        sel;
    } ev_t;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] ins_mem_ins = 32'd0;
    logic        ins_mem_valid = 1'b0;
    logic        stall_in = 1'b0;
    logic [31:0] alu_output = 32'd0;
    logic        ins_mem_req;
    logic [31:0] ins_mem_addr;
    logic [3:0]  alu_opcode;
    logic        alu_sel_imm;
    logic [31:0] imm_gen_input;
    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [4:0]  rf_rd_addr;
    logic        rf_we;
    logic        halt;

    core_sequencer #(.RESET_PC(RST_PC)) dut (
        .CLOCK_50      (CLOCK_50),
        .RESET         (RESET),
        .ins_mem_ins   (ins_mem_ins),
        .ins_mem_valid (ins_mem_valid),
        .ins_mem_req   (ins_mem_req),
        .ins_mem_addr  (ins_mem_addr),
        .stall_in      (stall_in),
        .alu_output    (alu_output),
        .alu_opcode    (alu_opcode),
        .alu_sel_imm   (alu_sel_imm),
        .imm_gen_input (imm_gen_input),
        .rf_rs1_addr   (rf_rs1_addr),
        .rf_rs2_addr   (rf_rs2_addr),
        .rf_rd_addr    (rf_rd_addr),
        .rf_we         (rf_we),
        .halt          (halt)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    ev_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_on = 0;
    logic halt_prev = 1'b0;

    function automatic ev_t mk(input logic [1:0] k, input logic [31:0] a,
                               input logic [4:0] rd, input logic [3:0] op,
                               input logic sel);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.rd   = rd;
        e.op   = op;
        e.sel  = sel;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic sb_compare(input string name, input ev_t act);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: unexpected event %h, queue empty", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got %h want %h", name, act, e);
            end
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (mon_on) begin
            if (ins_mem_req && ins_mem_valid)
                sb_compare("fetch", mk(K_FETCH, ins_mem_addr, 5'd0, 4'd0, 1'b0));
            if (rf_we)
                sb_compare("wb", mk(K_WB, ins_mem_addr, rf_rd_addr,
                                    alu_opcode, alu_sel_imm));
            if (halt && !halt_prev)
                sb_compare("halt", mk(K_HALT, ins_mem_addr, 5'd0, 4'd0, 1'b0));
        end
        halt_prev = halt;
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 16 && !ins_mem_req; i++) step();
        check("req_wait", {31'd0, ins_mem_req}, 32'd1);
    endtask

    // waits for a fetch, holds valid low for dly cycles, then presents ins
    task automatic fetch(input logic [31:0] ins, input int dly,
                         input logic [31:0] addr, input logic [31:0] old_ir);
        wait_req();
        for (int i = 0; i < dly; i++) begin
            ins_mem_ins   = 32'hDEAD_BEEF;
            ins_mem_valid = 1'b0;
            check("wait_addr", ins_mem_addr, addr);
            check("wait_req", {31'd0, ins_mem_req}, 32'd1);
            check("wait_ir", imm_gen_input, old_ir);
            step();
        end
        ins_mem_ins   = ins;
        ins_mem_valid = 1'b1;
        step();
        ins_mem_valid = 1'b0;
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] addr,
                       input logic [4:0] rd, input logic [3:0] op,
                       input logic sel);
        exp_q.push_back(mk(K_FETCH, addr, 5'd0, 4'd0, 1'b0));
        exp_q.push_back(mk(K_WB, addr, rd, op, sel));
        fetch(ins, 0, addr, imm_gen_input);
        step();
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        RESET    = 1'b1;
        stall_in = 1'b1;
        step();
        step();
        check("rst_req", {31'd0, ins_mem_req}, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_pc", ins_mem_addr, RST_PC);
        check("rst_op", {28'd0, alu_opcode}, 32'd0);
        check("rst_sel", {31'd0, alu_sel_imm}, 32'd0);
        check("rst_ir", imm_gen_input, 32'd0);
        stall_in = 1'b0;
        mon_on   = 1'b1;
        RESET    = 1'b0;

        // add x3,x1,x2 with valid in the first fetch cycle
        exp_q.push_back(mk(K_FETCH, RST_PC, 5'd0, 4'd0, 1'b0));
        exp_q.push_back(mk(K_WB, RST_PC, 5'd3, 4'd0, 1'b0));
        fetch(32'h0020_81B3, 0, RST_PC, 32'd0);
        step();
        check("add_op", {28'd0, alu_opcode}, 32'd0);
        check("add_sel", {31'd0, alu_sel_imm}, 32'd0);
        check("add_rd", {27'd0, rf_rd_addr}, 32'd3);
        check("add_rs", {22'd0, rf_rs2_addr, rf_rs1_addr}, {22'd0, 5'd2, 5'd1});
        check("add_we_c3", {31'd0, rf_we}, 32'd0);
        step();
        check("add_we_c4", {31'd0, rf_we}, 32'd1);
        step();
        check("add_we_off", {31'd0, rf_we}, 32'd0);
        check("add_pc", ins_mem_addr, 32'hFFFF_FFFC);

        // srai x5,x6,3 at 0xFFFFFFFC with valid delayed 3 cycles
        exp_q.push_back(mk(K_FETCH, 32'hFFFF_FFFC, 5'd0, 4'd0, 1'b0));
        exp_q.push_back(mk(K_WB, 32'hFFFF_FFFC, 5'd5, 4'd7, 1'b1));
        fetch(32'h4033_5293, 3, 32'hFFFF_FFFC, 32'h0020_81B3);
        check("srai_ir", imm_gen_input, 32'h4033_5293);
        ins_mem_ins   = 32'hFFFF_FFFF;
        ins_mem_valid = 1'b1;
        step();
        ins_mem_valid = 1'b0;
        check("ir_hold", imm_gen_input, 32'h4033_5293);
        step();
        step();
        check("pc_wrap", ins_mem_addr, 32'd0);

        // sub x5,x6,x7 with a 2-cycle stall in writeback
        exp_q.push_back(mk(K_FETCH, 32'd0, 5'd0, 4'd0, 1'b0));
        exp_q.push_back(mk(K_WB, 32'd0, 5'd5, 4'd1, 1'b0));
        fetch(32'h4073_02B3, 0, 32'd0, imm_gen_input);
        step();
        step();
        stall_in = 1'b1;
        #1;
        check("stall_we0", {31'd0, rf_we}, 32'd0);
        step();
        check("stall_we1", {31'd0, rf_we}, 32'd0);
        check("stall_pc", ins_mem_addr, 32'd0);
        step();
        check("stall_we2", {31'd0, rf_we}, 32'd0);
        stall_in = 1'b0;
        #1;
        check("stall_pulse", {31'd0, rf_we}, 32'd1);
        step();
        check("stall_after", {31'd0, rf_we}, 32'd0);
        check("stall_pc_adv", ins_mem_addr, 32'd4);

        // illegal word halts until reset
        exp_q.push_back(mk(K_FETCH, 32'd4, 5'd0, 4'd0, 1'b0));
        exp_q.push_back(mk(K_HALT, 32'd4, 5'd0, 4'd0, 1'b0));
        fetch(32'hFFFF_FFFF, 0, 32'd4, imm_gen_input);
        step();
        for (int i = 0; i < 4; i++) begin
            check("halt_on", {31'd0, halt}, 32'd1);
            check("halt_req", {31'd0, ins_mem_req}, 32'd0);
            step();
        end
        RESET    = 1'b1;
        stall_in = 1'b1;
        step();
        check("rst2_pc", ins_mem_addr, RST_PC);
        check("rst2_halt", {31'd0, halt}, 32'd0);
        check("rst2_req", {31'd0, ins_mem_req}, 32'd0);
        RESET    = 1'b0;
        stall_in = 1'b0;

        // walk the PC up to 0x10 with addi x1,x0,i
        a = RST_PC;
        for (int i = 0; i < 6; i++) begin
            run(32'h0000_0093 | (32'(i) << 20), a, 5'd1, 4'd0, 1'b1);
            a = a + 32'd4;
        end
        check("pc_at_10", ins_mem_addr, 32'h10);

        // beq x1,x2,+8 at 0x10 with a zero ALU result
        alu_output = 32'd0;
        exp_q.push_back(mk(K_FETCH, 32'h10, 5'd0, 4'd0, 1'b0));
`ifdef CORE_SEQ_BRANCH_EN
        fetch(32'h0020_8463, 0, 32'h10, imm_gen_input);
        step();
        check("beq_op", {28'd0, alu_opcode}, 32'd1);
        step();
        check("beq_we", {31'd0, rf_we}, 32'd0);
        step();
        check("beq_target", ins_mem_addr, 32'h18);
        run(32'h0050_0093, 32'h18, 5'd1, 4'd0, 1'b1);
`else
        exp_q.push_back(mk(K_HALT, 32'h10, 5'd0, 4'd0, 1'b0));
        fetch(32'h0020_8463, 0, 32'h10, imm_gen_input);
        step();
        check("beq_halt", {31'd0, halt}, 32'd1);
        check("beq_req", {31'd0, ins_mem_req}, 32'd0);
        check("beq_pc", ins_mem_addr, 32'h10);
`endif
        step();
        step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d events left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 CLOCK_50  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 ins_mem_ins  input  32  instruction word from instruction memory.
REQ-005 ins_mem_valid  input  1  ins_mem_ins is valid this cycle.
REQ-006 ins_mem_req  output  1  fetch request for the word at ins_mem_addr.
REQ-007 ins_mem_addr  output  32  current PC.
REQ-008 stall_in  input  1  freeze request from the surrounding core.
REQ-009 alu_output  input  32  ALU result, used for branch resolution.
REQ-010 alu_opcode  output  4  ALU operation: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
REQ-011 alu_sel_imm  output  1  1 selects immediate as ALU operand B, 0 selects rs2.
REQ-012 imm_gen_input  output  32  latched instruction register (IR) driven to the immediate generator.
REQ-013 rf_rs1_addr, rf_rs2_addr, rf_rd_addr  output  5 each  IR[19:15], IR[24:20], IR[11:7].
REQ-014 rf_we  output  1  one-cycle register-file write strobe.
REQ-015 halt  output  1  sticky halt indication.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT; IDLE->FETCH unconditionally.
REQ-017 FETCH: ins_mem_req=1 with ins_mem_addr=PC; on ins_mem_valid=1, IR<=ins_mem_ins and next state is DECODE; otherwise remain in FETCH.
REQ-018 ins_mem_valid outside FETCH SHALL be ignored; IR is unchanged.
REQ-019 DECODE: opcode 0x33 (OP) maps funct3/funct7[5] to alu_opcode with alu_sel_imm=0; 0x13 (OP-IMM) maps likewise with alu_sel_imm=1 (funct7[5] honoured only for SRAI); any other opcode -> HALT.
REQ-020 alu_opcode and alu_sel_imm SHALL be registered in DECODE and held through EXECUTE and WRITEBACK.
REQ-021 EXECUTE lasts one cycle; WRITEBACK asserts rf_we=1 for exactly one cycle for OP/OP-IMM, then PC<=PC+4, next state FETCH.
REQ-022 Latency: 4 cycles per non-branch instruction when ins_mem_valid arrives in the first FETCH cycle.
REQ-023 PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 -> 32'h0000_0000.
REQ-024 stall_in=1 SHALL freeze state, PC, IR and registered outputs; rf_we is forced 0 while stalled and asserts in the first unstalled WRITEBACK cycle; ins_mem_req stays asserted if stalled in FETCH.
REQ-025 HALT: ins_mem_req=0, rf_we=0, halt=1; only RESET exits.

Reset
REQ-026 On RESET=1: state=IDLE, PC=RESET_PC, IR=0, ins_mem_req=0, alu_opcode=0, alu_sel_imm=0, rf_we=0, halt=0.
REQ-027 RESET overrides stall_in, and a reset asserted mid-fetch SHALL drop ins_mem_req in the following cycle.

Configuration
REQ-028 With CORE_SEQ_BRANCH_EN defined, opcode 0x63 is decoded: BEQ/BNE -> SUB (taken on alu_output==0 / !=0), BLT/BGE -> SLT, BLTU/BGEU -> SLTU (taken on alu_output[0]==1 / ==0); rf_we=0; PC<=PC+B-immediate if taken, else PC+4.
REQ-029 With CORE_SEQ_BRANCH_EN defined, a taken target with bits[1:0]!=0 -> HALT, PC unchanged.
REQ-030 Without CORE_SEQ_BRANCH_EN, opcode 0x63 is illegal -> HALT.

Structure
REQ-031 Shared package core101_pkg SHALL hold the FSM state enum, ALU opcode constants and RISC-V major opcode constants.
REQ-032 One combinational sub-module core_seq_decoder (IR -> alu_opcode, alu_sel_imm, wb_en, is_branch, illegal) is used; all state is in core_sequencer.

Verification
REQ-033 Reset, then IR=32'h0020_81B3 (add x3,x1,x2) with valid in the first FETCH cycle -> alu_opcode=0, alu_sel_imm=0, rf_rd_addr=3, rf_we pulse at cycle 4, PC=4.
REQ-034 ins_mem_valid delayed 3 cycles -> ins_mem_req held with addr stable for 3 cycles; IR loaded only on the valid cycle.
REQ-035 IR=32'hFFFF_FFFF -> halt=1, ins_mem_req=0 forever; RESET -> PC=RESET_PC, halt=0.
REQ-036 stall_in held 2 cycles in WRITEBACK -> rf_we=0 for those cycles, single pulse afterwards, PC advances once.
REQ-037 PC=32'hFFFF_FFFC with an OP-IMM instruction -> next fetch address 32'h0000_0000.
REQ-038 CORE_SEQ_BRANCH_EN defined, BEQ with offset +8 and alu_output=0 at PC=0x10 -> next PC=0x18; without the macro -> halt=1.
